// File: rtl/rob_param_if.sv
// Reorder buffer bus: decode allocation, two writeback channels, commit/flush outputs.
// Optional q0/q1 rename lookup ports exist only when ROB_OPERAND_FWD_EN is defined.
interface rob_param_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int XLEN       = 32,
  parameter int RD_W       = 5
);
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [DEPTH_LOG2-1:0] alloc_tag;
  logic [RD_W-1:0]       alloc_rd;
  logic [XLEN-1:0]       alloc_pc;
  logic [XLEN-1:0]       alloc_pred_npc;
  logic                  alloc_is_store;
  logic                  alloc_is_branch;

  logic                  wb0_valid;
  logic [DEPTH_LOG2-1:0] wb0_tag;
  logic [XLEN-1:0]       wb0_data;
  logic [XLEN-1:0]       wb0_npc;
  logic                  wb1_valid;
  logic [DEPTH_LOG2-1:0] wb1_tag;
  logic [XLEN-1:0]       wb1_data;

  logic                  commit_valid;
  logic [DEPTH_LOG2-1:0] commit_tag;
  logic [RD_W-1:0]       commit_rd;
  logic [XLEN-1:0]       commit_data;
  logic                  commit_is_store;
  logic                  flush_valid;
  logic [XLEN-1:0]       flush_pc;
  logic [DEPTH_LOG2:0]   count;

`ifdef ROB_OPERAND_FWD_EN
  logic [DEPTH_LOG2-1:0] q0_tag;
  logic [DEPTH_LOG2-1:0] q1_tag;
  logic                  q0_ready;
  logic                  q1_ready;
  logic [XLEN-1:0]       q0_data;
  logic [XLEN-1:0]       q1_data;
`endif

  modport master (
    output alloc_valid, alloc_rd, alloc_pc, alloc_pred_npc, alloc_is_store, alloc_is_branch,
    output wb0_valid, wb0_tag, wb0_data, wb0_npc, wb1_valid, wb1_tag, wb1_data,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_data,
    input  commit_is_store, flush_valid, flush_pc, count
`ifdef ROB_OPERAND_FWD_EN
    , output q0_tag, q1_tag
    , input  q0_ready, q1_ready, q0_data, q1_data
`endif
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_pc, alloc_pred_npc, alloc_is_store, alloc_is_branch,
    input  wb0_valid, wb0_tag, wb0_data, wb0_npc, wb1_valid, wb1_tag, wb1_data,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_data,
    output commit_is_store, flush_valid, flush_pc, count
`ifdef ROB_OPERAND_FWD_EN
    , input  q0_tag, q1_tag
    , output q0_ready, q1_ready, q0_data, q1_data
`endif
  );
endinterface

// File: rtl/rob_param.sv
// In-order-commit reorder buffer with two writeback channels and commit-time mispredict flush.
// Macro ROB_OPERAND_FWD_EN adds combinational q0/q1 operand lookup ports for rename.
module rob_param #(
  parameter int DEPTH_LOG2 = 4,
  parameter int XLEN       = 32,
  parameter int RD_W       = 5
) (
  input logic      i_clk,
  input logic      i_rst,
  rob_param_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH-1:0]      r_busy, r_done, r_is_store, r_is_branch;
  logic [RD_W-1:0]       r_rd       [DEPTH];
  logic [XLEN-1:0]       r_pred_npc [DEPTH];
  logic [XLEN-1:0]       r_act_npc  [DEPTH];
  logic [XLEN-1:0]       r_data     [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head, r_tail;
  logic [DEPTH_LOG2:0]   r_count;

  logic                  r_commit_valid, r_commit_is_store, r_flush_valid;
  logic [DEPTH_LOG2-1:0] r_commit_tag;
  logic [RD_W-1:0]       r_commit_rd;
  logic [XLEN-1:0]       r_commit_data, r_flush_pc;

  logic w_alloc_ready, w_alloc_fire, w_commit, w_mispredict, w_wb0_hit, w_wb1_hit;

  // The flush pulse itself blocks allocation, giving decode a one-cycle bubble.
  assign w_alloc_ready = (r_count != CNT_FULL) && !r_flush_valid;
  assign w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
  assign w_commit      = r_busy[r_head] && r_done[r_head];
  assign w_mispredict  = w_commit && r_is_branch[r_head] &&
                         (r_act_npc[r_head] != r_pred_npc[r_head]);
  assign w_wb0_hit     = bus.wb0_valid && r_busy[bus.wb0_tag];
  assign w_wb1_hit     = bus.wb1_valid && r_busy[bus.wb1_tag];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy            <= '0;
      r_done            <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_commit_valid    <= 1'b0;
      r_commit_tag      <= '0;
      r_commit_rd       <= '0;
      r_commit_data     <= '0;
      r_commit_is_store <= 1'b0;
      r_flush_valid     <= 1'b0;
      r_flush_pc        <= '0;
    end else begin
      r_commit_valid <= w_commit;
      r_flush_valid  <= w_mispredict;
      if (w_commit) begin
        r_commit_tag      <= r_head;
        r_commit_rd       <= r_rd[r_head];
        r_commit_data     <= r_data[r_head];
        r_commit_is_store <= r_is_store[r_head];
      end
      if (w_mispredict) begin
        r_flush_pc <= r_act_npc[r_head];
        r_busy     <= '0;
        r_done     <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else begin
        if (w_alloc_fire) begin
          r_busy[r_tail]      <= 1'b1;
          r_done[r_tail]      <= 1'b0;
          r_rd[r_tail]        <= bus.alloc_rd;
          r_pred_npc[r_tail]  <= bus.alloc_pred_npc;
          r_is_store[r_tail]  <= bus.alloc_is_store;
          r_is_branch[r_tail] <= bus.alloc_is_branch;
          r_tail              <= r_tail + PTR_ONE;
        end
        // wb0 is applied last so it overrides wb1 on a shared tag.
        if (w_wb1_hit) begin
          r_done[bus.wb1_tag] <= 1'b1;
          r_data[bus.wb1_tag] <= bus.wb1_data;
        end
        if (w_wb0_hit) begin
          r_done[bus.wb0_tag]    <= 1'b1;
          r_data[bus.wb0_tag]    <= bus.wb0_data;
          r_act_npc[bus.wb0_tag] <= bus.wb0_npc;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + PTR_ONE;
        end
        case ({w_alloc_fire, w_commit})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign bus.alloc_ready     = w_alloc_ready;
  assign bus.alloc_tag       = r_tail;
  assign bus.commit_valid    = r_commit_valid;
  assign bus.commit_tag      = r_commit_tag;
  assign bus.commit_rd       = r_commit_rd;
  assign bus.commit_data     = r_commit_data;
  assign bus.commit_is_store = r_commit_is_store;
  assign bus.flush_valid     = r_flush_valid;
  assign bus.flush_pc        = r_flush_pc;
  assign bus.count           = r_count;

`ifdef ROB_OPERAND_FWD_EN
  logic w_q0_wb0, w_q0_wb1, w_q1_wb0, w_q1_wb1;
  assign w_q0_wb0 = w_wb0_hit && (bus.wb0_tag == bus.q0_tag);
  assign w_q0_wb1 = w_wb1_hit && (bus.wb1_tag == bus.q0_tag);
  assign w_q1_wb0 = w_wb0_hit && (bus.wb0_tag == bus.q1_tag);
  assign w_q1_wb1 = w_wb1_hit && (bus.wb1_tag == bus.q1_tag);

  assign bus.q0_ready = w_q0_wb0 || w_q0_wb1 || (r_busy[bus.q0_tag] && r_done[bus.q0_tag]);
  assign bus.q1_ready = w_q1_wb0 || w_q1_wb1 || (r_busy[bus.q1_tag] && r_done[bus.q1_tag]);
  assign bus.q0_data  = w_q0_wb0 ? bus.wb0_data :
                        w_q0_wb1 ? bus.wb1_data : r_data[bus.q0_tag];
  assign bus.q1_data  = w_q1_wb0 ? bus.wb0_data :
                        w_q1_wb1 ? bus.wb1_data : r_data[bus.q1_tag];
`endif
endmodule
